lcd_text_engine: RTL and testbench

LCD_TEXT_ENGINE -- requirements
Module: lcd_text_engine

---
 rtl/lcd_text_engine.sv | 165 ++++++++++++++++
 tb/tb_lcd_text_engine.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_engine.sv
// HD44780-style character LCD refresher. A ROWS x COLS shadow buffer is written
// at any time; dirty rows are streamed to the panel after the power-up init.
module lcd_text_engine #(
  parameter int COLS    = 16,
  parameter int ROWS    = 2,
  parameter int PWR_DLY = 750000,
  parameter int E_PULSE = 25,
  parameter int CMD_DLY = 2500,
  parameter int CLR_DLY = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [1:0] wr_row,
  input  logic [5:0] wr_col,
  input  logic [7:0] wr_char,
  input  logic       clr_req,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       init_done,
  output logic       busy
);
  localparam int CW     = 32;
  localparam int CELLS  = ROWS * COLS;
  localparam int IW     = $clog2(CELLS);
  localparam int N_INIT = 5;

  typedef enum logic [2:0] {
    PWR_WAIT, INIT, IDLE, ROW_ADDR, ROW_DATA, SETUP, STROBE, HOLD
  } state_t;

  state_t          state, state_next, ret_state;
  logic [CW-1:0]   cnt;
  logic [2:0]      init_idx;
  logic [1:0]      sel_row, low_row;
  logic [5:0]      col;
  logic            tx_rs;
  logic [7:0]      tx_data, cur_char, row_addr;
  logic [ROWS-1:0] dirty;
  logic [7:0]      buffer [CELLS];
  logic [IW-1:0]   wr_idx, rd_idx;
  logic            wr_ok;
  int              hold_dly;

  // True when the counter value c marks the n-th cycle of a wait.
  function automatic logic reached(input logic [CW-1:0] c, input int n);
    return ({1'b0, c} + 33'd1) >= 33'(n);
  endfunction

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1: return 8'h38;
      3'd2:       return 8'h0C;
      3'd3:       return 8'h01;
      default:    return 8'h06;
    endcase
  endfunction

  always_comb begin
    wr_ok    = wr_en && (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);
    wr_idx   = IW'(int'(wr_row) * COLS + int'(wr_col));
    rd_idx   = IW'(int'(sel_row) * COLS + int'(col));
    cur_char = buffer[rd_idx];
    hold_dly = (!tx_rs && tx_data == 8'h01) ? CLR_DLY : CMD_DLY;
    low_row  = '0;
    for (int r = ROWS - 1; r >= 0; r--)
      if (dirty[r]) low_row = 2'(r);
    case (sel_row)
      2'd0:    row_addr = 8'h00;
      2'd1:    row_addr = 8'h40;
      2'd2:    row_addr = 8'(COLS);
      default: row_addr = 8'(64 + COLS);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= PWR_WAIT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      PWR_WAIT: if (reached(cnt, PWR_DLY)) state_next = INIT;
      INIT:     state_next = (init_idx == 3'(N_INIT)) ? IDLE : SETUP;
      IDLE:     if (|dirty) state_next = ROW_ADDR;
      ROW_ADDR: state_next = SETUP;
      ROW_DATA: state_next = (col == 6'(COLS)) ? IDLE : SETUP;
      SETUP:    state_next = STROBE;
      STROBE:   if (reached(cnt, E_PULSE)) state_next = HOLD;
      HOLD:     if (reached(cnt, hold_dly)) state_next = ret_state;
      default:  state_next = PWR_WAIT;
    endcase
  end

  // cnt restarts at the lcd_e rise, so HOLD measures the delay from that rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      init_idx  <= '0;
      sel_row   <= '0;
      col       <= '0;
      tx_rs     <= 1'b0;
      tx_data   <= 8'h00;
      ret_state <= INIT;
      init_done <= 1'b0;
    end else begin
      if (state == SETUP)  cnt <= '0;
      else if (cnt != '1) cnt <= cnt + 1'b1;
      case (state)
        INIT: begin
          if (init_idx == 3'(N_INIT)) begin
            init_done <= 1'b1;
          end else begin
            tx_rs     <= 1'b0;
            tx_data   <= init_cmd(init_idx);
            init_idx  <= init_idx + 1'b1;
            ret_state <= INIT;
          end
        end
        IDLE: if (|dirty) sel_row <= low_row;
        ROW_ADDR: begin
          tx_rs     <= 1'b0;
          tx_data   <= 8'h80 | row_addr;
          col       <= '0;
          ret_state <= ROW_DATA;
        end
        ROW_DATA: if (col != 6'(COLS)) begin
          tx_rs     <= 1'b1;
          ret_state <= ROW_DATA;
        end
        SETUP: if (tx_rs) begin
          tx_data <= cur_char;
          col     <= col + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A write landing on the row being sent re-dirties it, so it wins over the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CELLS; i++) buffer[i] <= 8'h20;
      dirty <= '1;
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        if (clr_req || (wr_ok && int'(wr_row) == r)) dirty[r] <= 1'b1;
        else if (state == ROW_ADDR && int'(sel_row) == r) dirty[r] <= 1'b0;
      end
      for (int i = 0; i < CELLS; i++) begin
        if (wr_ok && int'(wr_idx) == i) buffer[i] <= wr_char;
        else if (clr_req)               buffer[i] <= 8'h20;
      end
    end
  end

  assign lcd_e    = (state == STROBE);
  assign lcd_rw   = 1'b0;
  assign lcd_rs   = tx_rs;
  assign lcd_data = (state == SETUP && tx_rs) ? cur_char : tx_data;
  assign busy     = (state != IDLE) || (|dirty);
endmodule

// File: tb/tb_lcd_text_engine.sv
// Bench for lcd_text_engine: captures every lcd_e transfer and compares the
// stream, timing and strobe stability against a shadow-screen model.
module tb_lcd_text_engine;
  localparam int COLS = 16, ROWS = 2;
  localparam int PWR_DLY = 100, E_PULSE = 4, CMD_DLY = 20, CLR_DLY = 50;

  logic       clk = 1'b0;
  logic       reset, wr_en, clr_req;
  logic [1:0] wr_row;
  logic [5:0] wr_col;
  logic [7:0] wr_char;
  logic       lcd_rs, lcd_rw, lcd_e, init_done, busy;
  logic [7:0] lcd_data;

  lcd_text_engine #(
    .COLS(COLS), .ROWS(ROWS), .PWR_DLY(PWR_DLY), .E_PULSE(E_PULSE),
    .CMD_DLY(CMD_DLY), .CLR_DLY(CLR_DLY)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_char(wr_char), .clr_req(clr_req), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_e(lcd_e), .lcd_data(lcd_data), .init_done(init_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0, miscompares = 0;
  logic [7:0] model [ROWS][COLS];
  logic [8:0] exp_q[$];
  logic [8:0] cap_q[$];
  int         cap_t[$];
  logic       cap_id[$];
  int         rel = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_range(input string tag, input int got, input int lo, input int hi);
    vectors++;
    assert (got >= lo && got <= hi) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d..%0d", tag, got, lo, hi);
    end
  endtask

  // Transfer monitor, sampled on the falling edge.
  logic       prev_e = 1'b0;
  logic [8:0] prev_bus = '0, held = '0;
  int         e_width = 0;
  always @(negedge clk) begin
    if (lcd_e && !prev_e) begin
      check("setup_stable", {lcd_rs, lcd_data}, prev_bus);
      check("rw_low", lcd_rw, 1'b0);
      cap_q.push_back({lcd_rs, lcd_data});
      cap_t.push_back(cyc);
      cap_id.push_back(init_done);
      held = {lcd_rs, lcd_data};
      e_width = 1;
    end else if (lcd_e) begin
      check("strobe_stable", {lcd_rs, lcd_data}, held);
      e_width++;
    end else if (prev_e && reset !== 1'b1) begin
      check("e_width", e_width, E_PULSE);
    end
    prev_e = lcd_e;
    prev_bus = {lcd_rs, lcd_data};
  end

  task automatic clear_cap();
    cap_q.delete(); cap_t.delete(); cap_id.delete(); exp_q.delete();
  endtask

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) model[r][c] = 8'h20;
  endtask

  task automatic push_init();
    exp_q.push_back(9'h038); exp_q.push_back(9'h038); exp_q.push_back(9'h00C);
    exp_q.push_back(9'h001); exp_q.push_back(9'h006);
  endtask

  task automatic push_row(input int r);
    int addr_tab[4];
    addr_tab = '{0, 'h40, COLS, 'h40 + COLS};
    exp_q.push_back({1'b0, 8'h80 | 8'(addr_tab[r])});
    for (int c = 0; c < COLS; c++) exp_q.push_back({1'b1, model[r][c]});
  endtask

  task automatic wr(input logic [1:0] row, input logic [5:0] col, input logic [7:0] ch, input logic clr);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_row = row; wr_col = col; wr_char = ch; clr_req = clr;
    @(posedge clk); #1;
    wr_en = 1'b0; clr_req = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    rel = cyc;
    clear_cap();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    repeat (2) @(negedge clk);
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s_idle", tag), busy, 1'b0);
  endtask

  task automatic check_burst(input string tag);
    int dly;
    check($sformatf("%s_len", tag), cap_q.size(), exp_q.size());
    if (cap_q.size() == exp_q.size()) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        check($sformatf("%s_xfer%0d", tag, i), cap_q[i], exp_q[i]);
        if (i > 0) begin
          dly = (exp_q[i-1] == 9'h001) ? CLR_DLY : CMD_DLY;
          check_range($sformatf("%s_gap%0d", tag, i), cap_t[i] - cap_t[i-1], dly + 1, dly + 4);
        end
      end
    end
  endtask

  task automatic check_powerup(input string tag);
    check($sformatf("%s_xfer_seen", tag), cap_t.size() > 5, 1'b1);
    if (cap_t.size() > 5) begin
      check_range($sformatf("%s_pwr_wait", tag), cap_t[0] - rel, PWR_DLY + 1, PWR_DLY + 4);
      check($sformatf("%s_init_done_low", tag), cap_id[4], 1'b0);
      check($sformatf("%s_init_done_high", tag), cap_id[5], 1'b1);
    end
    check($sformatf("%s_init_done_end", tag), init_done, 1'b1);
  endtask

  task automatic quiet_window(input string tag, input int cycles);
    logic busy_hit = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_hit = 1'b1;
    end
    check($sformatf("%s_busy", tag), busy_hit, 1'b0);
    check($sformatf("%s_no_xfer", tag), cap_q.size(), 0);
  endtask

  initial begin
    int r, c, n;
    logic [7:0] ch;
    reset = 1'b1; wr_en = 1'b0; clr_req = 1'b0;
    wr_row = '0; wr_col = '0; wr_char = '0;
    model_reset();

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_e", lcd_e, 1'b0);
    check("rst_rs", lcd_rs, 1'b0);
    check("rst_rw", lcd_rw, 1'b0);
    check("rst_data", lcd_data, 8'h00);
    check("rst_init_done", init_done, 1'b0);
    check("rst_busy", busy, 1'b1);

    // Power-up, init and first full redraw as spaces
    release_reset();
    push_init(); push_row(0); push_row(1);
    wait_idle("init", 5000);
    check_burst("init");
    check_powerup("init");

    // Single write to (1,3) while idle
    clear_cap();
    wr(2'd1, 6'd3, 8'h41, 1'b0);
    model[1][3] = 8'h41;
    push_row(1);
    wait_idle("wr13", 2000);
    check_burst("wr13");

    // Randomized writes, some out of range
    for (int k = 0; k < 10; k++) begin
      clear_cap();
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 3);
        c = (r >= ROWS) ? $urandom_range(0, 63) : $urandom_range(COLS, 63);
        wr(2'(r), 6'(c), 8'($urandom), 1'b0);
        quiet_window($sformatf("rnd%0d_oor", k), 30);
      end else begin
        r = $urandom_range(0, ROWS - 1);
        c = $urandom_range(0, COLS - 1);
        ch = 8'($urandom_range(33, 126));
        wr(2'(r), 6'(c), ch, 1'b0);
        model[r][c] = ch;
        push_row(r);
        wait_idle($sformatf("rnd%0d", k), 2000);
        check_burst($sformatf("rnd%0d", k));
      end
    end

    // Write to the row in flight at column 5
    clear_cap();
    ch = 8'($urandom_range(33, 126));
    wr(2'd0, 6'd0, ch, 1'b0);
    model[0][0] = ch;
    n = 0;
    while (cap_q.size() < 7 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("midrow_reached", cap_q.size() >= 7, 1'b1);
    wr(2'd0, 6'd15, 8'h41, 1'b0);
    model[0][15] = 8'h41;
    push_row(0); push_row(0);
    wait_idle("midrow", 3000);
    check_burst("midrow");

    // Out-of-range writes are ignored; row 0 refresh shows nothing aliased
    clear_cap();
    wr(2'd2, 6'd0, 8'h51, 1'b0);
    wr(2'd1, 6'd16, 8'h52, 1'b0);
    quiet_window("oor", 40);
    clear_cap();
    ch = 8'($urandom_range(33, 126));
    wr(2'd0, 6'd7, ch, 1'b0);
    model[0][7] = ch;
    push_row(0);
    wait_idle("oor_row0", 2000);
    check_burst("oor_row0");

    // Clear together with a write to (0,0)
    clear_cap();
    wr(2'd0, 6'd0, 8'h5A, 1'b1);
    model_reset();
    model[0][0] = 8'h5A;
    push_row(0); push_row(1);
    wait_idle("clr", 3000);
    check_burst("clr");

    // Reset while lcd_e is high, write during power-up wait
    clear_cap();
    wr(2'd1, 6'($urandom_range(0, COLS - 1)), 8'h33, 1'b0);
    n = 0;
    while (lcd_e !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_e", lcd_e, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_e", lcd_e, 1'b0);
    check("mid_rst_init_done", init_done, 1'b0);
    check("mid_rst_busy", busy, 1'b1);
    check("mid_rst_bus", {lcd_rs, lcd_data}, 9'h000);
    repeat (2) @(negedge clk);
    release_reset();
    model_reset();
    c = $urandom_range(0, COLS - 1);
    ch = 8'($urandom_range(33, 126));
    wr(2'd1, 6'(c), ch, 1'b0);
    model[1][c] = ch;
    push_init(); push_row(0); push_row(1);
    wait_idle("rst2", 5000);
    check_burst("rst2");
    check_powerup("rst2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
